// File: rtl/tx_frame_arbiter_pkg.sv
// Shared encodings for the TX frame arbiter: its own FSM states, the TX core
// state codes it observes, and FIFO / enable level names.
package tx_frame_arbiter_pkg;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b0_0001,
    ST_GRANT = 5'b0_0010,
    ST_XFER  = 5'b0_0100,
    ST_DRAIN = 5'b0_1000,
    ST_GAP   = 5'b1_0000
  } arb_state_e;

  localparam logic [4:0] TX_INTERVAL = 5'b0_0001;
  localparam logic [4:0] TX_STARTBIT = 5'b0_0010;
  localparam logic [4:0] TX_DATABIT  = 5'b0_0100;
  localparam logic [4:0] TX_PARITY   = 5'b0_1000;
  localparam logic [4:0] TX_STOPBIT  = 5'b1_0000;

  localparam logic FIFO_EMPTY    = 1'b1;
  localparam logic FIFO_NONEMPTY = 1'b0;

  localparam logic ARB_ENABLE  = 1'b1;
  localparam logic ARB_DISABLE = 1'b0;

endpackage

// File: rtl/tx_frame_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr+1,
// wrapping, returned one-hot.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick
);

  int unsigned idx;
  logic        found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = (32'(ptr) + off) % N;
      if (!found && req[PW'(idx)]) begin
        pick[PW'(idx)] = 1'b1;
        found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding one UART TX FIFO from REQ_NUM
// byte-stream requesters, with drain wait and baud-tick inter-frame gap.
module tx_frame_arbiter
  import tx_frame_arbiter_pkg::*;
#(
  parameter int unsigned REQ_NUM   = 4,
  parameter logic [15:0] MAX_FRAME = 16'd256,
  parameter logic [3:0]  GAP_BITS  = 4'd2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p_Enable_i,
  input  logic                 p_BaudSig_i,
  input  logic [4:0]           TxState_i,
  input  logic                 p_FiFoFull_i,
  input  logic                 p_FiFoEmpty_i,
  input  logic [REQ_NUM-1:0]   p_Req_i,
  input  logic [REQ_NUM-1:0]   p_Last_i,
  input  logic [8*REQ_NUM-1:0] Data_i,
  output logic [REQ_NUM-1:0]   p_Ack_o,
  output logic [REQ_NUM-1:0]   Grant_o,
  output logic [7:0]           FifoData_o,
  output logic                 p_FifoWr_o,
  output logic                 p_Busy_o,
  output logic                 p_FrameDone_o,
  output logic                 p_Overrun_o
);

  localparam int unsigned PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  arb_state_e         state, state_nxt;
  logic [REQ_NUM-1:0] grant_q, grant_nxt, pick, ack;
  logic [PTR_W-1:0]   ptr_q, ptr_nxt, grant_idx;
  logic [15:0]        byte_cnt, byte_cnt_nxt;
  logic [3:0]         gap_cnt, gap_cnt_nxt;
  logic [7:0]         wdata;
  logic               done, ovr;

  rr_pick #(.N(REQ_NUM), .PW(PTR_W)) u_pick (
    .req  (p_Req_i),
    .ptr  (ptr_q),
    .pick (pick)
  );

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++)
      if (grant_q[i]) grant_idx = PTR_W'(i);
  end

  always_comb begin
    wdata = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++)
      if (ack[i]) wdata = Data_i[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      grant_q  <= '0;
      ptr_q    <= PTR_W'(REQ_NUM - 1);
      byte_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      grant_q  <= grant_nxt;
      ptr_q    <= ptr_nxt;
      byte_cnt <= byte_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_q;
    ptr_nxt      = ptr_q;
    byte_cnt_nxt = byte_cnt;
    gap_cnt_nxt  = gap_cnt;
    ack          = '0;
    done         = 1'b0;
    ovr          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (p_Enable_i == ARB_ENABLE && |p_Req_i) begin
          grant_nxt = pick;
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        byte_cnt_nxt = '0;
        state_nxt    = ST_XFER;
      end
      ST_XFER: begin
        ack = grant_q & p_Req_i & {REQ_NUM{~p_FiFoFull_i}};
        if (|ack) begin
          byte_cnt_nxt = byte_cnt + 16'd1;
          // Last takes precedence over truncation on the same byte
          if (|(ack & p_Last_i)) begin
            state_nxt = ST_DRAIN;
          end else if (byte_cnt_nxt == MAX_FRAME) begin
            ovr       = 1'b1;
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (p_FiFoEmpty_i == FIFO_EMPTY && TxState_i == TX_INTERVAL) begin
          done        = 1'b1;
          ptr_nxt     = grant_idx;
          grant_nxt   = '0;
          gap_cnt_nxt = '0;
          state_nxt   = (GAP_BITS == 4'd0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (p_BaudSig_i) begin
          gap_cnt_nxt = gap_cnt + 4'd1;
          if (gap_cnt_nxt == GAP_BITS) state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  assign p_Ack_o       = ack;
  assign Grant_o       = grant_q;
  assign FifoData_o    = wdata;
  assign p_FifoWr_o    = |ack;
  assign p_Busy_o      = (state != ST_IDLE);
  assign p_FrameDone_o = done;
  assign p_Overrun_o   = ovr;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter (REQ_NUM=4, MAX_FRAME=4, GAP_BITS=2).
module tb_tx_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, baud, full, empty;
  logic [4:0]  txs;
  logic [3:0]  req, last;
  logic [31:0] data;
  logic [3:0]  ack, gnt;
  logic [7:0]  fdat;
  logic        wr, busy, done, ovr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tx_frame_arbiter #(.REQ_NUM(4), .MAX_FRAME(16'd4), .GAP_BITS(4'd2)) dut (
    .clk           (clk),
    .rst           (rst),
    .p_Enable_i    (en),
    .p_BaudSig_i   (baud),
    .TxState_i     (txs),
    .p_FiFoFull_i  (full),
    .p_FiFoEmpty_i (empty),
    .p_Req_i       (req),
    .p_Last_i      (last),
    .Data_i        (data),
    .p_Ack_o       (ack),
    .Grant_o       (gnt),
    .FifoData_o    (fdat),
    .p_FifoWr_o    (wr),
    .p_Busy_o      (busy),
    .p_FrameDone_o (done),
    .p_Overrun_o   (ovr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample outputs at the falling edge, return just after the rising edge.
  task automatic cyc(input string tag, input logic [3:0] e_ack, input logic e_wr,
                     input logic [7:0] e_dat, input logic [3:0] e_gnt, input logic e_busy,
                     input logic e_done, input logic e_ovr);
    @(negedge clk);
    chk({tag, ".ack"},   32'(ack),  32'(e_ack));
    chk({tag, ".wr"},    32'(wr),   32'(e_wr));
    chk({tag, ".data"},  32'(fdat), 32'(e_dat));
    chk({tag, ".grant"}, 32'(gnt),  32'(e_gnt));
    chk({tag, ".busy"},  32'(busy), 32'(e_busy));
    chk({tag, ".done"},  32'(done), 32'(e_done));
    chk({tag, ".ovr"},   32'(ovr),  32'(e_ovr));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".grant"}, 32'(gnt),  32'h0);
    chk({tag, ".wr"},    32'(wr),   32'h0);
    chk({tag, ".busy"},  32'(busy), 32'h0);
    chk({tag, ".ack"},   32'(ack),  32'h0);
    chk({tag, ".data"},  32'(fdat), 32'h0);
    chk({tag, ".done"},  32'(done), 32'h0);
    chk({tag, ".ovr"},   32'(ovr),  32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g;
    logic [7:0] d;
    rst = 1'b0; en = 1'b1; baud = 1'b0; full = 1'b0; empty = 1'b1;
    txs = 5'b0_0001; req = '0; last = '0; data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b1;

    // Single requester 0, three bytes
    req = 4'b0001; data = 32'h0000_00A5;
    cyc("t1.idle",  4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0);
    cyc("t1.grant", 4'b0000, 0, 8'h00, 4'b0001, 1, 0, 0);
    cyc("t1.b0",    4'b0001, 1, 8'hA5, 4'b0001, 1, 0, 0);
    data = 32'h0000_005A; empty = 1'b0; txs = 5'b0_0010;
    cyc("t1.b1",    4'b0001, 1, 8'h5A, 4'b0001, 1, 0, 0);
    data = 32'h0000_00FF; last = 4'b0001;
    cyc("t1.b2",    4'b0001, 1, 8'hFF, 4'b0001, 1, 0, 0);
    req = '0; last = '0; data = '0;
    cyc("t1.dr0",   4'b0000, 0, 8'h00, 4'b0001, 1, 0, 0);
    empty = 1'b1; txs = 5'b1_0000;
    cyc("t1.dr1",   4'b0000, 0, 8'h00, 4'b0001, 1, 0, 0);
    empty = 1'b0; txs = 5'b0_0001;
    cyc("t1.dr2",   4'b0000, 0, 8'h00, 4'b0001, 1, 0, 0);
    empty = 1'b1;
    cyc("t1.done",  4'b0000, 0, 8'h00, 4'b0001, 1, 1, 0);
    cyc("t1.gap0",  4'b0000, 0, 8'h00, 4'b0000, 1, 0, 0);
    baud = 1'b1;
    cyc("t1.gap1",  4'b0000, 0, 8'h00, 4'b0000, 1, 0, 0);
    baud = 1'b0;
    cyc("t1.gap2",  4'b0000, 0, 8'h00, 4'b0000, 1, 0, 0);
    baud = 1'b1;
    cyc("t1.gap3",  4'b0000, 0, 8'h00, 4'b0000, 1, 0, 0);
    baud = 1'b0;
    cyc("t1.idle2", 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0);

    // Fresh reset so requester 0 leads the alternation
    rst = 1'b0;
    #1;
    chk_reset("reset2");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Requesters 0 and 2 with back-to-back one-byte frames
    req = 4'b0101; last = 4'b0101; data = 32'h0022_0011; baud = 1'b1;
    for (int f = 0; f < 4; f++) begin
      g = (f % 2 == 0) ? 4'b0001 : 4'b0100;
      d = (f % 2 == 0) ? 8'h11 : 8'h22;
      cyc("t2.idle",  4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0);
      cyc("t2.grant", 4'b0000, 0, 8'h00, g,       1, 0, 0);
      cyc("t2.xfer",  g,       1, d,     g,       1, 0, 0);
      cyc("t2.drain", 4'b0000, 0, 8'h00, g,       1, 1, 0);
      cyc("t2.gap0",  4'b0000, 0, 8'h00, 4'b0000, 1, 0, 0);
      cyc("t2.gap1",  4'b0000, 0, 8'h00, 4'b0000, 1, 0, 0);
    end

    // FIFO full stall on requester 1 (pointer at 2, so 1 is reached after wrap)
    req = 4'b0010; last = '0; data = 32'h0000_3100;
    cyc("t3.idle",  4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0);
    cyc("t3.grant", 4'b0000, 0, 8'h00, 4'b0010, 1, 0, 0);
    cyc("t3.b0",    4'b0010, 1, 8'h31, 4'b0010, 1, 0, 0);
    data = 32'h0000_3200; full = 1'b1;
    for (int i = 0; i < 5; i++)
      cyc("t3.full", 4'b0000, 0, 8'h00, 4'b0010, 1, 0, 0);
    full = 1'b0;
    cyc("t3.b1",    4'b0010, 1, 8'h32, 4'b0010, 1, 0, 0);
    data = 32'h0000_3300; last = 4'b0010;
    cyc("t3.b2",    4'b0010, 1, 8'h33, 4'b0010, 1, 0, 0);
    req = '0; last = '0;
    cyc("t3.drain", 4'b0000, 0, 8'h00, 4'b0010, 1, 1, 0);
    cyc("t3.gap0",  4'b0000, 0, 8'h00, 4'b0000, 1, 0, 0);
    cyc("t3.gap1",  4'b0000, 0, 8'h00, 4'b0000, 1, 0, 0);

    // Truncation at MAX_FRAME=4 on requester 3, resume on next grant
    req = 4'b1000; data = 32'h4100_0000;
    cyc("t4.idle",  4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0);
    cyc("t4.grant", 4'b0000, 0, 8'h00, 4'b1000, 1, 0, 0);
    cyc("t4.b1",    4'b1000, 1, 8'h41, 4'b1000, 1, 0, 0);
    data = 32'h4200_0000;
    cyc("t4.b2",    4'b1000, 1, 8'h42, 4'b1000, 1, 0, 0);
    data = 32'h4300_0000;
    cyc("t4.b3",    4'b1000, 1, 8'h43, 4'b1000, 1, 0, 0);
    data = 32'h4400_0000;
    cyc("t4.b4ovr", 4'b1000, 1, 8'h44, 4'b1000, 1, 0, 1);
    data = 32'h4500_0000;
    cyc("t4.drain", 4'b0000, 0, 8'h00, 4'b1000, 1, 1, 0);
    cyc("t4.gap0",  4'b0000, 0, 8'h00, 4'b0000, 1, 0, 0);
    cyc("t4.gap1",  4'b0000, 0, 8'h00, 4'b0000, 1, 0, 0);
    cyc("t4.idle2", 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0);
    cyc("t4.grnt2", 4'b0000, 0, 8'h00, 4'b1000, 1, 0, 0);
    cyc("t4.b5",    4'b1000, 1, 8'h45, 4'b1000, 1, 0, 0);
    data = 32'h4600_0000; last = 4'b1000;
    cyc("t4.b6",    4'b1000, 1, 8'h46, 4'b1000, 1, 0, 0);
    req = '0; last = '0; data = '0;
    cyc("t4.drn2",  4'b0000, 0, 8'h00, 4'b1000, 1, 1, 0);
    cyc("t4.gap2",  4'b0000, 0, 8'h00, 4'b0000, 1, 0, 0);
    cyc("t4.gap3",  4'b0000, 0, 8'h00, 4'b0000, 1, 0, 0);

    // Enable dropped mid-frame: frame completes, no new grant while low
    req = 4'b0001; data = 32'h0000_0051;
    cyc("t5.idle",  4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0);
    cyc("t5.grant", 4'b0000, 0, 8'h00, 4'b0001, 1, 0, 0);
    cyc("t5.b0",    4'b0001, 1, 8'h51, 4'b0001, 1, 0, 0);
    en = 1'b0; data = 32'h0000_0052; last = 4'b0001;
    cyc("t5.b1",    4'b0001, 1, 8'h52, 4'b0001, 1, 0, 0);
    req = 4'b0110; last = '0; data = 32'h0000_6100;
    cyc("t5.drain", 4'b0000, 0, 8'h00, 4'b0001, 1, 1, 0);
    cyc("t5.gap0",  4'b0000, 0, 8'h00, 4'b0000, 1, 0, 0);
    cyc("t5.gap1",  4'b0000, 0, 8'h00, 4'b0000, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc("t5.held", 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0);
    en = 1'b1;
    cyc("t5.idle2", 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0);
    cyc("t5.grnt2", 4'b0000, 0, 8'h00, 4'b0010, 1, 0, 0);
    cyc("t5.xfer",  4'b0010, 1, 8'h61, 4'b0010, 1, 0, 0);

    // Asynchronous reset while in XFER
    rst = 1'b0;
    #1;
    chk_reset("t6.rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 4'b0111; data = 32'h0000_0071;
    cyc("t6.idle",  4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0);
    cyc("t6.grant", 4'b0000, 0, 8'h00, 4'b0001, 1, 0, 0);
    cyc("t6.xfer",  4'b0001, 1, 8'h71, 4'b0001, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_frame_arbiter.md
Name:
tx_frame_arbiter

Overview:
- Frame-granular round-robin arbiter that shares one UART TX path (TX FIFO + TX core state machine) between REQ_NUM byte-stream requesters.
- Grants one requester at a time and forwards its bytes into the TX FIFO until the frame's last byte.
- Waits for the TX core to drain the frame onto the wire, then enforces an inter-frame gap in baud ticks before re-arbitrating.
- Sits between the application-side sources and the TX FIFO; observes the TX core state output.

Parameters:
- REQ_NUM, 4, number of requesters (2..8).
- MAX_FRAME, 16'd256, maximum bytes per frame before forced truncation.
- GAP_BITS, 4'd2, idle baud ticks between frames; 0 means no gap.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- p_Enable_i  input  1  arbitration enable; low blocks new grants only.
- p_BaudSig_i  input  1  one-clk baud tick from the baud generator.
- TxState_i  input  5  TX core one-hot state; INTERVAL=5'b0_0001.
- p_FiFoFull_i  input  1  TX FIFO full.
- p_FiFoEmpty_i  input  1  TX FIFO empty.
- p_Req_i  input  REQ_NUM  per-requester byte valid.
- p_Last_i  input  REQ_NUM  per-requester last-byte-of-frame flag, qualified by p_Req_i.
- Data_i  input  8*REQ_NUM  per-requester byte; requester k uses bits [8k+7:8k].
- p_Ack_o  output  REQ_NUM  byte accepted this cycle (one-hot or zero).
- Grant_o  output  REQ_NUM  registered one-hot owner of the TX path.
- FifoData_o  output  8  byte to FIFO.
- p_FifoWr_o  output  1  FIFO write strobe.
- p_Busy_o  output  1  high in any state other than IDLE.
- p_FrameDone_o  output  1  one-clk pulse when the granted frame has fully left the wire.
- p_Overrun_o  output  1  one-clk pulse when a frame is truncated at MAX_FRAME.

Behaviour:
- States are one-hot:
  - IDLE=5'b0_0001
  - GRANT=5'b0_0010
  - XFER=5'b0_0100
  - DRAIN=5'b0_1000
  - GAP=5'b1_0000
  - Illegal codes go to IDLE with Grant_o cleared.
- Reset values:
  - state IDLE; Grant_o=0; byte count=0; gap count=0.
  - priority pointer = REQ_NUM-1, so requester 0 wins first.
  - All pulses and p_Ack_o/p_FifoWr_o are 0; FifoData_o=8'h00.
- IDLE: if p_Enable_i=1 and |p_Req_i, pick the first requester with Req set, scanning pointer+1 upward with wrap. Register its one-hot in Grant_o and go to GRANT. Otherwise stay.
- GRANT: one cycle for the Grant_o setup; clears byte count; goes to XFER.
- XFER acceptance:
  - Ack = Grant_o & p_Req_i & ~p_FiFoFull_i, combinational, zero latency.
  - p_FifoWr_o = |Ack; FifoData_o = granted requester's byte (8'h00 when no write).
  - Each write increments the 16-bit byte count.
- XFER exits (when several hold, the first listed wins):
  - Accepted byte with p_Last_i set → DRAIN.
  - Count reaches MAX_FRAME on a write without Last → pulse p_Overrun_o and go to DRAIN. The truncated frame's remaining bytes stay un-acked until that requester's next grant.
  - A requester dropping Req mid-frame just stalls XFER. There is no timeout.
- DRAIN: wait until p_FiFoEmpty_i=1 and TxState_i==INTERVAL in the same cycle. Then pulse p_FrameDone_o, set pointer to the granted index, and clear Grant_o. Go to GAP, or to IDLE directly when GAP_BITS=0.
- GAP: count p_BaudSig_i ticks; at the GAP_BITS-th tick go to IDLE.
- p_Enable_i low during GRANT/XFER/DRAIN/GAP: the current frame completes normally; only IDLE is gated.
- Simultaneous Req edges: only the registered Grant_o matters. Requests from non-granted channels are never acked.
- Asynchronous reset mid-frame: everything returns to reset values immediately; partial FIFO content is the FIFO owner's concern.

Decomposition:
- Shared package or header holds:
  - the state encodings IDLE..GAP;
  - TX core state constants (INTERVAL, STOPBIT, etc.), reused from the TX core definitions;
  - EMPTY/NONEMPTY and ENABLE/DISABLE constants.
- Sub-module rr_pick: combinational round-robin selector (request vector + pointer → one-hot). It is the only natural split.

Test Plan:
- Single requester 0 sends 3 bytes 8'hA5,8'h5A,8'hFF (Last on the third), FIFO never full → three consecutive p_FifoWr_o pulses with matching FifoData_o. p_FrameDone_o fires after TxState_i returns to INTERVAL with the FIFO empty, then 2 baud ticks of GAP, then IDLE.
- Requesters 0 and 2 both request continuously with 1-byte frames → grant order 0,2,0,2. A requester never receives Ack while not granted.
- p_FiFoFull_i held high for 5 cycles mid-frame → p_Ack_o and p_FifoWr_o are 0 for those cycles; no byte is lost or duplicated.
- MAX_FRAME=4, requester sends 6 bytes with no Last → 4 writes, then a p_Overrun_o pulse. The next grant to the same requester resumes with byte 5.
- p_Enable_i dropped during XFER → the frame finishes and p_FrameDone_o pulses. No new grant occurs while Enable=0 despite pending requests.
- rst asserted during XFER → Grant_o=0, p_FifoWr_o=0 and state IDLE immediately. After release, requester 0 has first priority.
